// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO.
// Features: exact occupancy level, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, and a registered read port.
// Optional feature macro: PARAM_SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads (combinational head word, rd_valid tied low). When it is undefined,
// reads are registered and rd_valid marks a freshly popped word.
module param_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    // Storage array; deliberately not reset so it can map onto RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic wa;
    logic ra;

    // Status flags decode only the level register, so they never glitch.
    assign full         = (level_q == DEPTH_L);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Requests are qualified against the pre-edge full/empty state.
    assign wa = wr_en & ~full;
    assign ra = rd_en & ~empty;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wa) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (ra) begin
            rptr_d = rptr_q + AW'(1);
        end

        case ({wa, ra})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A new error in the same cycle as err_clr keeps the flag set.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port; only accepted writes touch the array.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wptr_q] <= wr_data;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head word is presented directly; consumers treat !empty as valid.
    assign rd_data  = mem[rptr_q];
    assign rd_valid = 1'b0;
`else
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    // Capture the head word on an accepted read, otherwise hold it.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = ra;
        if (ra) begin
            rd_data_d = mem[rptr_q];
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed testbench for param_sync_fifo (DEPTH=16, AF=14, AE=2).
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] level;
    logic       overflow, underflow;

    int checks = 0;
    int failures = 0;

    param_sync_fifo #(
        .WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       ec;
        logic [4:0] lvl;
        logic       f;
        logic       e;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic       rv;
        logic [7:0] rdd;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, sample 1 time unit after posedge.
    task automatic drive(input logic we, input logic [7:0] wd, input logic re, input logic ec);
        @(negedge clk);
        wr_en = we; wr_data = wd; rd_en = re; err_clr = ec;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        $display("txn we=%0b wd=%02h re=%0b ec=%0b -> level=%0d rd_valid=%0b rd_data=%02h ovf=%0b unf=%0b",
                 we, wd, re, ec, level, rd_valid, rd_data, overflow, underflow);
    endtask

    // In FWFT builds the head word is visible before the pop.
    task automatic check_head(input string name, input logic [7:0] exp);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        @(negedge clk);
        chk(name, 32'(rd_data), 32'(exp));
`else
        if (name.len() < 0) $display("%02h", exp);
`endif
    endtask

    // Standard builds: check registered read data after the pop edge.
    task automatic check_pop(input string name, input logic [7:0] exp);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
        chk({name, "_rv"}, 32'(rd_valid), 32'd1);
        chk(name, 32'(rd_data), 32'(exp));
`else
        if (name.len() < 0) $display("%02h", exp);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_af"}, 32'(almost_full), 32'd0);
        chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_unf"}, 32'(underflow), 32'd0);
        chk({tag, "_rv"}, 32'(rd_valid), 32'd0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
        chk({tag, "_rdd"}, 32'(rd_data), 32'd0);
`endif
    endtask

    initial begin
        //           we  wd     re  ec   lvl f  e  af ae ovf unf rv rdd
        vecs[0]  = '{1, 8'h55, 1, 0,  5'd1, 0, 0, 0, 1, 0, 1, 0, 8'h00};
        vecs[1]  = '{0, 8'h00, 1, 0,  5'd0, 0, 1, 0, 1, 0, 1, 1, 8'h55};
        vecs[2]  = '{0, 8'h00, 0, 1,  5'd0, 0, 1, 0, 1, 0, 0, 0, 8'h55};
        vecs[3]  = '{0, 8'h00, 1, 0,  5'd0, 0, 1, 0, 1, 0, 1, 0, 8'h55};
        vecs[4]  = '{0, 8'h00, 1, 1,  5'd0, 0, 1, 0, 1, 0, 1, 0, 8'h55};
        vecs[5]  = '{0, 8'h00, 0, 1,  5'd0, 0, 1, 0, 1, 0, 0, 0, 8'h55};
        vecs[6]  = '{1, 8'h11, 0, 0,  5'd1, 0, 0, 0, 1, 0, 0, 0, 8'h55};
        vecs[7]  = '{1, 8'h22, 0, 0,  5'd2, 0, 0, 0, 1, 0, 0, 0, 8'h55};
        vecs[8]  = '{1, 8'h33, 0, 0,  5'd3, 0, 0, 0, 0, 0, 0, 0, 8'h55};
        vecs[9]  = '{1, 8'h44, 1, 0,  5'd3, 0, 0, 0, 0, 0, 0, 1, 8'h11};
        vecs[10] = '{0, 8'h00, 1, 0,  5'd2, 0, 0, 0, 1, 0, 0, 1, 8'h22};
        vecs[11] = '{0, 8'h00, 1, 0,  5'd1, 0, 0, 0, 1, 0, 0, 1, 8'h33};
        vecs[12] = '{0, 8'h00, 1, 0,  5'd0, 0, 1, 0, 1, 0, 0, 1, 8'h44};

        // Power-on reset values, no clock edge needed.
        #1;
        check_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors: empty corner cases, err_clr priority, small pipeline.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].ec);
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].f));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e));
            chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(vecs[i].af));
            chk($sformatf("v%0d_ae", i), 32'(almost_empty), 32'(vecs[i].ae));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(vecs[i].unf));
`ifndef PARAM_SYNC_FIFO_FWFT_EN
            chk($sformatf("v%0d_rv", i), 32'(rd_valid), 32'(vecs[i].rv));
            chk($sformatf("v%0d_rdd", i), 32'(rd_data), 32'(vecs[i].rdd));
`else
            chk($sformatf("v%0d_rv", i), 32'(rd_valid), 32'd0);
`endif
        end

        // Fill 0x00..0x0F and watch almost_full / full.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
            chk($sformatf("fill%0d_af", i), 32'(almost_full), 32'((i + 1) >= 14));
            chk($sformatf("fill%0d_full", i), 32'(full), 32'((i + 1) == 16));
        end

        // 17th write rejected.
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);

        // err_clr together with a new overflow: set wins.
        drive(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("ovf_setwins", 32'(overflow), 32'd1);
        chk("ovf_setwins_level", 32'(level), 32'd16);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous read/write: read accepted, write rejected.
        check_head("fullrw_head", 8'h00);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("fullrw_level", 32'(level), 32'd15);
        chk("fullrw_ovf", 32'(overflow), 32'd1);
        check_pop("fullrw_rdd", 8'h00);

        // Drain the rest; 0xAA must never appear.
        for (int i = 1; i < 16; i++) begin
            check_head($sformatf("drain%0d_head", i), 8'(i));
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("drain%0d_level", i), 32'(level), 32'(15 - i));
            chk($sformatf("drain%0d_ae", i), 32'(almost_empty), 32'((15 - i) <= 2));
            chk($sformatf("drain%0d_empty", i), 32'(empty), 32'((15 - i) == 0));
            check_pop($sformatf("drain%0d_rdd", i), 8'(i));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_unf", 32'(underflow), 32'd1);
        chk("drain_unf_rv", 32'(rd_valid), 32'd0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
        chk("drain_unf_rdd_hold", 32'(rd_data), 32'h0F);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("errs_clear", 32'({overflow, underflow}), 32'd0);

        // Wrap-around: steady level 3 with concurrent read/write.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        end
        for (int k = 0; k < 40; k++) begin
            check_head($sformatf("wrap%0d_head", k), 8'(8'hC0 + k));
            drive(1'b1, 8'(8'hC3 + k), 1'b1, 1'b0);
            chk($sformatf("wrap%0d_level", k), 32'(level), 32'd3);
            check_pop($sformatf("wrap%0d_rdd", k), 8'(8'hC0 + k));
        end
        chk("wrap_errs", 32'({overflow, underflow}), 32'd0);

        // Asynchronous reset mid-burst at level 5.
        drive(1'b1, 8'hD0, 1'b0, 1'b0);
        drive(1'b1, 8'hD1, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_level", 32'(level), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_wr_level", 32'(level), 32'd1);
        check_head("post_rst_head", 8'h77);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_pop("post_rst_rdd", 8'h77);
        chk("post_rst_final_level", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
